// File: rtl/seg7_defs_pkg.sv
// Shared 7-segment definitions: cathode glyphs, anode scan codes and special digit codes.
// Used by both the display driver and the scan capture side.
package seg7_defs_pkg;

    // Active-low cathode glyphs, bit7 = DP
    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_C     = 8'hC6;
    localparam logic [7:0] GLYPH_BLANK = 8'hAA;

    localparam logic [3:0] ANODE_D0 = 4'b0111;
    localparam logic [3:0] ANODE_D1 = 4'b1011;
    localparam logic [3:0] ANODE_D2 = 4'b1101;
    localparam logic [3:0] ANODE_D3 = 4'b1110;

    localparam logic [3:0] CODE_C     = 4'hC;
    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_ERR   = 4'hF;

    typedef struct packed {
        logic [3:0] anode;
        logic [7:0] cathode;
    } scan_sample_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] pos;
    } anode_dec_t;

    // Map an anode scan code to its digit position; exactly one low line is legal
    function automatic anode_dec_t decode_anode(input logic [3:0] anode);
        anode_dec_t dec;
        dec = '{legal: 1'b1, pos: 2'd0};
        case (anode)
            ANODE_D0: dec.pos = 2'd0;
            ANODE_D1: dec.pos = 2'd1;
            ANODE_D2: dec.pos = 2'd2;
            ANODE_D3: dec.pos = 2'd3;
            default:  dec.legal = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational cathode-pattern to digit-code decoder; unknown patterns give CODE_ERR.
module seg7_glyph_decode
    import seg7_defs_pkg::*;
(
    input  logic [7:0] cathode,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code    = CODE_ERR;
        illegal = 1'b0;
        case (cathode)
            GLYPH_0:     code = 4'h0;
            GLYPH_1:     code = 4'h1;
            GLYPH_2:     code = 4'h2;
            GLYPH_3:     code = 4'h3;
            GLYPH_4:     code = 4'h4;
            GLYPH_5:     code = 4'h5;
            GLYPH_6:     code = 4'h6;
            GLYPH_7:     code = 4'h7;
            GLYPH_8:     code = 4'h8;
            GLYPH_9:     code = 4'h9;
            GLYPH_C:     code = CODE_C;
            GLYPH_BLANK: code = CODE_BLANK;
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Watches a multiplexed 7-segment scan, qualifies each dwell and rebuilds the four digit codes.
// Flags completed frames, illegal glyphs and a stalled scan.
module seg7_scan_capture
    import seg7_defs_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TIMEOUT_W      = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] anode_in,
    input  logic [7:0] cathode_in,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit_valid,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       stale
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0]    STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] IDLE_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] IDLE_MAX  = TIMEOUT_W'(TIMEOUT_CYCLES);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    scan_sample_t          sample_q;
    scan_sample_t          held_q;
    logic [STAB_W-1:0]     stab_cnt;
    logic [TIMEOUT_W-1:0]  idle_cnt;
    logic [3:0]            seen_mask;
    logic [3:0]            digits [4];
    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic                  capture;
    logic                  same;
    anode_dec_t            anode_dec;
    logic [3:0]            pos_bit;
    logic [3:0]            glyph_code;
    logic                  glyph_illegal;

    assign same      = (sample_q == held_q);
    assign anode_dec = decode_anode(sample_q.anode);
    assign pos_bit   = 4'b0001 << anode_dec.pos;

    seg7_glyph_decode u_glyph (
        .cathode (sample_q.cathode),
        .code    (glyph_code),
        .illegal (glyph_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_HUNT;
        else       state <= state_nxt;
    end

    // A dwell is captured once, when it has stayed stable long enough while hunting
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        if (!same) begin
            state_nxt = ST_HUNT;
        end else if (state == ST_HUNT && stab_cnt == STAB_MAX && anode_dec.legal) begin
            capture   = 1'b1;
            state_nxt = ST_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q    <= scan_sample_t'('1);
            held_q      <= scan_sample_t'('1);
            stab_cnt    <= '0;
            idle_cnt    <= '0;
            seen_mask   <= '0;
            digits      <= '{default: 4'h0};
            digit_valid <= '0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
            stale       <= 1'b0;
        end else begin
            sample_q    <= {anode_in, cathode_in};
            held_q      <= sample_q;
            frame_valid <= 1'b0;

            if (!same)                     stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + STAB_W'(1);

            // A capture on the timeout edge wins and keeps the scan fresh
            if (capture) begin
                digits[anode_dec.pos]      <= glyph_code;
                digit_valid[anode_dec.pos] <= 1'b1;
                idle_cnt                   <= '0;
                stale                      <= 1'b0;
                if (glyph_illegal) decode_err <= 1'b1;
                if ((seen_mask | pos_bit) == 4'b1111) begin
                    frame_valid <= 1'b1;
                    seen_mask   <= '0;
                end else begin
                    seen_mask <= seen_mask | pos_bit;
                end
            end else if (idle_cnt == IDLE_LAST) begin
                idle_cnt    <= IDLE_MAX;
                stale       <= 1'b1;
                digit_valid <= '0;
                seen_mask   <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + TIMEOUT_W'(1);
            end
        end
    end

    assign digit0 = digits[0];
    assign digit1 = digits[1];
    assign digit2 = digits[2];
    assign digit3 = digits[3];

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomised scoreboard bench for seg7_scan_capture: a dwell-level reference model predicts
// every output change and its clock; a monitor pops and compares whenever the outputs move.
module tb_seg7_scan_capture;

    localparam int unsigned S  = 4;
    localparam int unsigned T  = 64;
    localparam int unsigned TW = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] anode_in = 4'hF;
    logic [7:0] cathode_in = 8'hFF;
    logic [3:0] digit0, digit1, digit2, digit3, digit_valid;
    logic       frame_valid, decode_err, stale;

    seg7_scan_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_W      (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .anode_in    (anode_in),
        .cathode_in  (cathode_in),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d3, d2, d1, d0;
        logic [3:0] valid;
        logic       fv, err, stl;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    localparam snap_t RESET_SNAP = '0;

    exp_t  q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;
    snap_t last_obs = RESET_SNAP;

    logic [7:0] glyphs [12] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                8'h82, 8'hF8, 8'h80, 8'h90, 8'hC6, 8'hAA};

    // Position of the single low anode line, -1 when not exactly one scan code
    function automatic int pos_of(input logic [3:0] a);
        for (int i = 0; i < 4; i++)
            if (a == ~(4'b1000 >> i)) return i;
        return -1;
    endfunction

    function automatic logic [3:0] code_of(input logic [7:0] c, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < 10; i++)
            if (c == glyphs[i]) return 4'(i);
        if (c == 8'hC6) return 4'hC;
        if (c == 8'hAA) return 4'hE;
        ok = 1'b0;
        return 4'hF;
    endfunction

    // Reference model state: run length of identical samples decides captures
    logic [3:0]  m_dig [4];
    logic [3:0]  m_valid, m_seen;
    bit          m_fv, m_err, m_stale, m_pend, m_cap, m_ok;
    int          m_idle, m_run, m_pos;
    logic [11:0] m_last, m_pend_s, m_cap_s, m_smp;
    snap_t       m_prev = RESET_SNAP;
    snap_t       m_now;

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_valid = '0; m_seen = '0; m_fv = 0; m_err = 0; m_stale = 0;
        m_idle = 0; m_run = 1; m_last = 12'hFFF; m_pend = 0; m_pend_s = '0;
    endtask

    initial m_reset();

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_reset();
        end else begin
            m_cap   = m_pend;
            m_cap_s = m_pend_s;
            m_smp   = {anode_in, cathode_in};
            if (m_smp == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run  = 1;
                m_last = m_smp;
            end
            m_pend   = (m_run == S + 1) && (pos_of(m_smp[11:8]) >= 0);
            m_pend_s = m_smp;
            m_fv     = 0;
            if (m_cap) begin
                m_pos = pos_of(m_cap_s[11:8]);
                m_dig[m_pos] = code_of(m_cap_s[7:0], m_ok);
                if (!m_ok) m_err = 1;
                m_valid[m_pos] = 1'b1;
                m_seen[m_pos]  = 1'b1;
                if (m_seen == 4'hF) begin
                    m_fv   = 1;
                    m_seen = '0;
                end
                m_idle  = 0;
                m_stale = 0;
            end else if (m_idle < T) begin
                m_idle++;
                if (m_idle == T) begin
                    m_stale = 1;
                    m_valid = '0;
                    m_seen  = '0;
                end
            end
        end
        m_now = {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, m_fv, m_err, m_stale};
        if (m_now != m_prev) q.push_back('{cyc: cyc, s: m_now});
        m_prev = m_now;
    end

    // Monitor: every change of the output bundle must match the next predicted event
    snap_t cur;
    exp_t  e;
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {digit3, digit2, digit1, digit0, digit_valid, frame_valid, decode_err, stale};
            if (cur !== last_obs) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.s || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL out_event cyc=%0d got=%h want=%h want_cyc=%0d",
                                 cyc, cur, e.s, e.cyc);
                    end
                end
                last_obs = cur;
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [7:0] c, input int n);
        repeat (n) begin
            @(negedge clk);
            anode_in   = a;
            cathode_in = c;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    logic [3:0] ra;
    logic [7:0] rc;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_flags", {29'h0, frame_valid, decode_err, stale}, 32'h0);
        q.delete();
        last_obs = RESET_SNAP;
        mon_en   = 1'b1;
        reset    = 1'b0;

        // Single held dwell, then one scan of four positions
        drive(4'b0111, 8'hB0, 10);
        drive(4'b0111, 8'hC0, 8);
        drive(4'b1011, 8'hF9, 8);
        drive(4'b1101, 8'hA4, 8);
        drive(4'b1110, 8'hC6, 8);

        // Cathode flicker faster than qualification
        for (int i = 0; i < 8; i++) drive(4'b1011, (i % 2) ? 8'h99 : 8'h82, 3);

        // Illegal anode, then illegal glyph
        drive(4'b0011, 8'h80, 20);
        drive(4'b1011, 8'hFF, 8);
        drive(4'b1011, 8'hC0, 8);

        // Stall into stale, partial frame across a second stall
        drive(4'hF, 8'hFF, 80);
        drive(4'b0111, 8'h92, 8);
        drive(4'b1011, 8'h82, 8);
        drive(4'hF, 8'hFF, 80);
        drive(4'b1101, 8'hF8, 8);
        drive(4'b1110, 8'h80, 8);
        drive(4'b0111, 8'h90, 8);
        drive(4'b1011, 8'hAA, 8);

        // Capture landing on the same edge as the timeout
        drive(4'b0111, 8'hC0, 8);
        drive(4'hF, 8'hFF, 56);
        drive(4'b1011, 8'hF9, 8);

        // Reset in the middle of a d2 dwell
        drive(4'b1101, 8'h92, 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1101, 8'h92, 10);

        // Random scan traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 99) < 85) ra = ~(4'b1000 >> $urandom_range(0, 3));
            else                            ra = 4'($urandom);
            if ($urandom_range(0, 99) < 85) rc = glyphs[$urandom_range(0, 11)];
            else                            rc = 8'($urandom);
            drive(ra, rc, $urandom_range(2, 10));
            if ($urandom_range(0, 99) < 3) begin
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        drive(4'hF, 8'hFF, 10);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
